// File: rtl/alu_exec_unit.sv
// Handshaked RV32I/M execute unit: decodes ALUOp/funct fields to a 5-bit op code
// and returns single-cycle results immediately, multiply/divide after DATA_WIDTH steps.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter bit MEXT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ALUOp,
    input  logic                  op_5,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  funct7_0,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            ALUControl,
    output logic                  illegal
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [4:0] C_ADD = 5'd0,  C_SUB = 5'd1,  C_AND = 5'd2,  C_OR = 5'd3,
                           C_SLT = 5'd4,  C_SLTU = 5'd5, C_XOR = 5'd6,  C_SLL = 5'd7,
                           C_SRL = 5'd8,  C_SRA = 5'd9,  C_MUL = 5'd10, C_MULH = 5'd11,
                           C_MULHSU = 5'd12, C_MULHU = 5'd13, C_DIV = 5'd14,
                           C_DIVU = 5'd15, C_REM = 5'd16, C_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_cnt;
    logic [W-1:0]    r_result, r_hi, r_lo, r_opb;
    logic [4:0]      r_ctrl;
    logic            r_illegal, r_is_mul, r_neg, r_neg_r;

    logic [4:0]      w_ctrl;
    logic            w_illegal, w_accept, w_is_mul, w_is_div, w_sgn_a, w_sgn_b;
    logic            w_sa, w_sb, w_div0, w_ovf, w_iter, w_ge;
    logic [W-1:0]    w_mag_a, w_mag_b, w_fast, w_nhi, w_nlo, w_quo, w_rem, w_final;
    logic [SW-1:0]   w_shamt;
    logic [W:0]      w_add, w_rsh, w_diff;
    logic [2*W-1:0]  w_prod, w_prod_s;

    // ---------------- decode ----------------
    always_comb begin
        w_ctrl    = C_ADD;
        w_illegal = 1'b0;
        case (ALUOp)
            3'b000: w_ctrl = C_ADD;
            3'b001: w_ctrl = C_SUB;
            3'b010: begin
                if (op_5 && funct7_0) begin
                    if (MEXT_EN) w_ctrl = C_MUL + {2'b00, funct3};
                    else         w_illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  w_ctrl = (op_5 && funct7_5) ? C_SUB : C_ADD;
                        3'b001:  w_ctrl = C_SLL;
                        3'b010:  w_ctrl = C_SLT;
                        3'b011:  w_ctrl = C_SLTU;
                        3'b100:  w_ctrl = C_XOR;
                        3'b101:  w_ctrl = funct7_5 ? C_SRA : C_SRL;
                        3'b110:  w_ctrl = C_OR;
                        default: w_ctrl = C_AND;
                    endcase
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_is_mul = !w_illegal && (w_ctrl >= C_MUL) && (w_ctrl <= C_MULHU);
    assign w_is_div = !w_illegal && (w_ctrl >= C_DIV);
    assign w_sgn_a  = (w_ctrl == C_MUL) || (w_ctrl == C_MULH) || (w_ctrl == C_MULHSU) ||
                      (w_ctrl == C_DIV) || (w_ctrl == C_REM);
    assign w_sgn_b  = (w_ctrl == C_MUL) || (w_ctrl == C_MULH) ||
                      (w_ctrl == C_DIV) || (w_ctrl == C_REM);
    assign w_sa     = w_sgn_a && src_a[W-1];
    assign w_sb     = w_sgn_b && src_b[W-1];
    assign w_mag_a  = w_sa ? -src_a : src_a;
    assign w_mag_b  = w_sb ? -src_b : src_b;
    assign w_div0   = w_is_div && (src_b == '0);
    // Only signed DIV/REM have w_sgn_b set among the divide ops.
    assign w_ovf    = w_is_div && w_sgn_b && (src_a == MOST_NEG) && (&src_b);
    assign w_iter   = (w_is_mul || w_is_div) && !w_div0 && !w_ovf;
    assign w_shamt  = src_b[SW-1:0];

    // ---------------- single-cycle results ----------------
    always_comb begin
        w_fast = '0;
        if (!w_illegal) begin
            case (w_ctrl)
                C_ADD:  w_fast = src_a + src_b;
                C_SUB:  w_fast = src_a - src_b;
                C_AND:  w_fast = src_a & src_b;
                C_OR:   w_fast = src_a | src_b;
                C_XOR:  w_fast = src_a ^ src_b;
                C_SLT:  w_fast = {{(W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                C_SLTU: w_fast = {{(W-1){1'b0}}, src_a < src_b};
                C_SLL:  w_fast = src_a << w_shamt;
                C_SRL:  w_fast = src_a >> w_shamt;
                C_SRA:  w_fast = $signed(src_a) >>> w_shamt;
                C_DIV, C_DIVU: w_fast = w_div0 ? '1 : src_a;
                C_REM, C_REMU: w_fast = w_div0 ? src_a : '0;
                default: w_fast = '0;
            endcase
        end
    end

    // ---------------- iterative mul/div step ----------------
    // r_hi:r_lo is the shift-add product register, or remainder:quotient.
    assign w_add  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : '0)};
    assign w_rsh  = {r_hi, r_lo[W-1]};
    assign w_diff = w_rsh - {1'b0, r_opb};
    assign w_ge   = !w_diff[W];

    always_comb begin
        if (r_is_mul) begin
            w_nhi = w_add[W:1];
            w_nlo = {w_add[0], r_lo[W-1:1]};
        end else begin
            w_nhi = w_ge ? w_diff[W-1:0] : w_rsh[W-1:0];
            w_nlo = {r_lo[W-2:0], w_ge};
        end
    end

    assign w_prod   = {w_nhi, w_nlo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -w_nlo : w_nlo;
    assign w_rem    = r_neg_r ? -w_nhi : w_nhi;

    always_comb begin
        case (r_ctrl)
            C_MUL:                   w_final = w_prod_s[W-1:0];
            C_MULH, C_MULHSU, C_MULHU: w_final = w_prod_s[2*W-1:W];
            C_DIV, C_DIVU:           w_final = w_quo;
            default:                 w_final = w_rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   r_state <= S_IDLE;
        else if (en) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = !w_accept ? S_IDLE : (w_iter ? S_BUSY : S_DONE);
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = en && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
        out_valid = (r_state == S_DONE);
    end

    assign w_accept = in_valid && in_ready;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_result  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_is_mul  <= 1'b0;
            r_neg     <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (en) begin
            if (w_accept) begin
                r_ctrl    <= w_ctrl;
                r_illegal <= w_illegal;
                r_cnt     <= '0;
                r_is_mul  <= w_is_mul;
                r_neg     <= w_sa ^ w_sb;
                r_neg_r   <= w_sa;
                r_hi      <= '0;
                r_lo      <= w_mag_a;
                r_opb     <= w_mag_b;
                if (!w_iter) r_result <= w_fast;
            end else if (r_state == S_BUSY) begin
                r_hi  <= w_nhi;
                r_lo  <= w_nlo;
                r_cnt <= r_cnt + 1'b1;
                // Sign fix-up folds into the last step so the result lands with DONE.
                if (r_cnt == CNT_LAST) r_result <= w_final;
            end
        end
    end

    assign result     = r_result;
    assign ALUControl = r_ctrl;
    assign illegal    = r_illegal;
endmodule
